axi_10g_ethernet_0_tx_arbiter: RTL and testbench
================================================

AXI_10G_ETHERNET_0_TX_ARBITER -- requirements
Module: axi_10g_ethernet_0_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 3, number of frame sources (0=ARP reply, 1=ICMP reply, 2=UDP tx).
REQ-002 SHALL have parameter GRANT_TIMEOUT, default 16, the number of cycles a granted source may wait before its first tvalid.
REQ-003 SHALL have port aclk, input, 1 bit; the single clock, all logic on its rising edge.
REQ-004 SHALL have port aresetn, input, 1 bit; asynchronous active-low reset.
REQ-005 SHALL have port src_req_en, input, NUM_SRC bits; per-source frame request (level, held until granted).
REQ-006 SHALL have port src_grant, output, NUM_SRC bits; one-hot grant, the source's tready-enable.
REQ-007 SHALL have port src_tdata, input, 64*NUM_SRC bits; packed per-source data, source i at [64i+63:64i].
REQ-008 SHALL have port src_tkeep, input, 8*NUM_SRC bits; packed per-source keep.
REQ-009 SHALL have port src_tvalid, input, NUM_SRC bits; per-source tvalid.
REQ-010 SHALL have port src_tlast, input, NUM_SRC bits; per-source tlast.
REQ-011 SHALL have port src_tready, output, NUM_SRC bits; per-source tready.
REQ-012 SHALL have port src_done, output, NUM_SRC bits; one-cycle pulse when that source's tlast beat is accepted.
REQ-013 SHALL have ports m_axis_tdata (output, 64), m_axis_tkeep (output, 8), m_axis_tvalid (output, 1) and m_axis_tlast (output, 1) toward the MAC tx; m_axis_tready (input, 1) from the MAC.
REQ-014 SHALL have port timeout_err, output, 1 bit; one-cycle pulse when a grant is revoked by timeout.

Function
REQ-015 SHALL implement FSM states IDLE, GRANT, XFER, GAP.
REQ-016 IDLE: when any src_req_en is set, SHALL pick the winner round-robin starting at rr_ptr, register it as sel, and go to GRANT; with no requests SHALL stay in IDLE.
REQ-017 GRANT/XFER: src_grant[sel]=1, all other grants 0; src_tready[sel]=m_axis_tready, all other src_tready 0.
REQ-018 GRANT/XFER: m_axis_* SHALL be a combinational mux of source sel (zero added latency); m_axis_tvalid=src_tvalid[sel].
REQ-019 In all other states m_axis_tvalid SHALL be 0 and m_axis_tdata/tkeep/tlast SHALL be 0.
REQ-020 GRANT: the first accepted beat (tvalid&tready) SHALL move to XFER; a first beat that also has tlast SHALL go directly to GAP.
REQ-021 GRANT: a 16-bit wait counter SHALL increment every cycle; reaching GRANT_TIMEOUT with no tvalid SHALL pulse timeout_err and go to GAP.
REQ-022 XFER: the grant SHALL be locked until the accepted tlast beat (tvalid&tready&tlast), then go to GAP; there is no timeout in XFER.
REQ-023 On accepted tlast, src_done[sel] SHALL pulse for exactly one cycle (registered, the cycle after acceptance).
REQ-024 GAP: SHALL last exactly one cycle with all grants 0, set rr_ptr=(sel+1) mod NUM_SRC, then go to IDLE.
REQ-025 Stalls (m_axis_tready=0) SHALL hold the state; data, keep and last SHALL pass through unchanged.
REQ-026 Simultaneous requests SHALL be served in rotation; no source SHALL be granted twice while another waits.
REQ-027 A requester dropping src_req_en after grant SHALL NOT revoke the grant; only tlast or the timeout ends it.
REQ-028 Requests arriving during XFER or GAP SHALL be held by the source and considered at the next IDLE.

Reset
REQ-029 aresetn low SHALL asynchronously force state=IDLE, sel=0, rr_ptr=0, wait counter=0, src_grant=0, src_tready=0, src_done=0, timeout_err=0 and all m_axis_* outputs 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no tlast emitted; after release, source 0 has first priority.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE/GRANT/XFER/GAP), the source index constants (SRC_ARP=0, SRC_ICMP=1, SRC_UDP=2) and the AXIS width constants (64/8).
REQ-032 The round-robin winner selection SHALL be one sub-module, axi_10g_ethernet_0_rr_pick (inputs req and ptr; outputs one-hot winner and index; purely combinational).

Verification
REQ-033 Single ICMP request of 5 beats, tready=1: grant[1] is high the cycle after the request, 5 beats pass unchanged, src_done[1] pulses once, then one GAP cycle.
REQ-034 All three requests at once, each 3 beats: order 0,1,2 with one idle GAP cycle between frames; then all requests again: order 1,2,0 if rr_ptr=1.
REQ-035 UDP frame of 4 beats with m_axis_tready toggling 1,0,0,1: no beat lost or duplicated, tdata at the MAC matches the source sequence.
REQ-036 ARP requests but never asserts tvalid, GRANT_TIMEOUT=16: timeout_err pulses 16 cycles after the grant, the grant drops, and the pending ICMP request is served next.
REQ-037 aresetn pulsed low during beat 2 of a 6-beat frame: all outputs 0 immediately; after release, a new request from source 0 is granted normally.
REQ-038 Single-beat frame (tvalid & tlast on the first beat): FSM goes GRANT->GAP->IDLE and src_done pulses once.

Source files
------------

// File: rtl/axi_10g_ethernet_0_tx_arbiter_pkg.sv
// Shared types and constants for the 10G Ethernet tx frame arbiter.
// Holds the FSM state encoding, the source slot numbers and the AXIS widths.
package axi_10g_ethernet_0_tx_arbiter_pkg;

    localparam int AXIS_DATA_W = 64;
    localparam int AXIS_KEEP_W = 8;
    localparam int WAIT_CNT_W  = 16;

    localparam int SRC_ARP  = 0;
    localparam int SRC_ICMP = 1;
    localparam int SRC_UDP  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2,
        GAP   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/axi_10g_ethernet_0_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
// Returns the winner both one-hot and as an index; both are zero with no requests.
module axi_10g_ethernet_0_rr_pick #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     winner,
    output logic [IDX_W-1:0] index
);

    always_comb begin
        int   cand;
        logic found;
        winner = '0;
        index  = '0;
        found  = 1'b0;
        cand   = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!found && req[cand]) begin
                found        = 1'b1;
                winner[cand] = 1'b1;
                index        = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/axi_10g_ethernet_0_tx_arbiter.sv
// Round-robin arbiter merging several AXIS frame sources onto the MAC tx stream.
// A grant is locked for a whole frame; a granted source that never sends is dropped after a timeout.
module axi_10g_ethernet_0_tx_arbiter
    import axi_10g_ethernet_0_tx_arbiter_pkg::*;
#(
    parameter int NUM_SRC       = 3,
    parameter int GRANT_TIMEOUT = 16
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [NUM_SRC-1:0]             src_req_en,
    output logic [NUM_SRC-1:0]             src_grant,
    input  logic [AXIS_DATA_W*NUM_SRC-1:0] src_tdata,
    input  logic [AXIS_KEEP_W*NUM_SRC-1:0] src_tkeep,
    input  logic [NUM_SRC-1:0]             src_tvalid,
    input  logic [NUM_SRC-1:0]             src_tlast,
    output logic [NUM_SRC-1:0]             src_tready,
    output logic [NUM_SRC-1:0]             src_done,
    output logic [AXIS_DATA_W-1:0]         m_axis_tdata,
    output logic [AXIS_KEEP_W-1:0]         m_axis_tkeep,
    output logic                           m_axis_tvalid,
    output logic                           m_axis_tlast,
    input  logic                           m_axis_tready,
    output logic                           timeout_err,
    output logic [1:0]                     dbg_state
);

    // Handshake: a beat moves when tvalid and tready are both high on a rising
    // aclk edge; the granted source sees the MAC's tready directly, others see 0.

    localparam int IDX_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int TIMEOUT_LAST = (GRANT_TIMEOUT > 0) ? GRANT_TIMEOUT - 1 : 0;

    arb_state_t              state;
    logic [IDX_W-1:0]        sel;
    logic [IDX_W-1:0]        rr_ptr;
    logic [IDX_W-1:0]        pick_idx;
    logic [NUM_SRC-1:0]      pick_onehot;
    logic [NUM_SRC-1:0]      grant_q;
    logic [NUM_SRC-1:0]      done_q;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    logic                    timeout_q;

    logic                    active;
    logic [AXIS_DATA_W-1:0]  sel_tdata;
    logic [AXIS_KEEP_W-1:0]  sel_tkeep;
    logic                    sel_tvalid;
    logic                    sel_tlast;
    logic                    beat_ok;
    logic                    last_ok;

    axi_10g_ethernet_0_rr_pick #(
        .N     (NUM_SRC),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (src_req_en),
        .ptr    (rr_ptr),
        .winner (pick_onehot),
        .index  (pick_idx)
    );

    always_comb begin
        sel_tdata  = src_tdata[AXIS_DATA_W*int'(sel) +: AXIS_DATA_W];
        sel_tkeep  = src_tkeep[AXIS_KEEP_W*int'(sel) +: AXIS_KEEP_W];
        sel_tvalid = src_tvalid[sel];
        sel_tlast  = src_tlast[sel];
    end

    // The MAC side is a pure mux of the selected source so no latency is added.
    assign active        = (state == GRANT) || (state == XFER);
    assign m_axis_tvalid = active & sel_tvalid;
    assign m_axis_tdata  = active ? sel_tdata : '0;
    assign m_axis_tkeep  = active ? sel_tkeep : '0;
    assign m_axis_tlast  = active & sel_tlast;
    assign beat_ok       = m_axis_tvalid & m_axis_tready;
    assign last_ok       = beat_ok & sel_tlast;

    assign src_grant   = grant_q;
    assign src_tready  = grant_q & {NUM_SRC{m_axis_tready}};
    assign src_done    = done_q;
    assign timeout_err = timeout_q;
    assign dbg_state   = state;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= IDLE;
            sel       <= '0;
            rr_ptr    <= '0;
            wait_cnt  <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            done_q    <= '0;
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (|src_req_en) begin
                        sel     <= pick_idx;
                        grant_q <= pick_onehot;
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                    if (last_ok) begin
                        done_q  <= grant_q;
                        grant_q <= '0;
                        state   <= GAP;
                    end else if (beat_ok) begin
                        state <= XFER;
                    end else if (!sel_tvalid && (wait_cnt >= WAIT_CNT_W'(TIMEOUT_LAST))) begin
                        // Source was granted but never produced a beat: revoke.
                        timeout_q <= 1'b1;
                        grant_q   <= '0;
                        state     <= GAP;
                    end
                end
                XFER: begin
                    if (last_ok) begin
                        done_q  <= grant_q;
                        grant_q <= '0;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    rr_ptr   <= (int'(sel) == NUM_SRC - 1) ? '0 : sel + 1'b1;
                    wait_cnt <= '0;
                    state    <= IDLE;
                end
                default: begin
                    grant_q <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_10g_ethernet_0_tx_arbiter.sv
// Self-checking bench for the tx arbiter: frame-level sources, a MAC-side beat
// scoreboard, a per-cycle rule checker and directed timing expectations.
module tb_axi_10g_ethernet_0_tx_arbiter;
    import axi_10g_ethernet_0_tx_arbiter_pkg::*;

    localparam int N   = 3;
    localparam int TMO = 16;

    logic            aclk    = 1'b0;
    logic            aresetn = 1'b0;
    logic [N-1:0]    src_req_en;
    logic [N-1:0]    src_grant;
    logic [64*N-1:0] src_tdata;
    logic [8*N-1:0]  src_tkeep;
    logic [N-1:0]    src_tvalid;
    logic [N-1:0]    src_tlast;
    logic [N-1:0]    src_tready;
    logic [N-1:0]    src_done;
    logic [63:0]     m_axis_tdata;
    logic [7:0]      m_axis_tkeep;
    logic            m_axis_tvalid;
    logic            m_axis_tlast;
    logic            m_axis_tready;
    logic            timeout_err;
    logic [1:0]      dbg_state;

    axi_10g_ethernet_0_tx_arbiter #(
        .NUM_SRC       (N),
        .GRANT_TIMEOUT (TMO)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .src_req_en    (src_req_en),
        .src_grant     (src_grant),
        .src_tdata     (src_tdata),
        .src_tkeep     (src_tkeep),
        .src_tvalid    (src_tvalid),
        .src_tlast     (src_tlast),
        .src_tready    (src_tready),
        .src_done      (src_done),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .timeout_err   (timeout_err),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 aclk = ~aclk;

    // ---------------- model state ----------------
    logic [72:0]  src_q [N][$];   // {last, keep, data} beats still to send
    logic [72:0]  exp_q [$];      // beats expected at the MAC, in arbitration order
    bit           in_frame [N];
    bit           silent [N];
    logic [N-1:0] acc_prev;
    logic [N-1:0] done_exp;
    logic [N-1:0] grant_prev;
    logic         to_exp;
    int           nv_cnt;
    bit           nv_seen;
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    int           frame_id = 0;
    int           to_cnt;
    int           to_cycle;
    int           done_cycle;
    int           done_cnt [N];
    int           grant_order [$];
    int           grant_cyc [$];
    logic [1:0]   st_at [256];
    bit           chk_en = 1'b0;

    task automatic check(input string name, input logic [73:0] act, input logic [73:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    function automatic int order_at(input int idx);
        return (idx < grant_order.size()) ? grant_order[idx] : -1;
    endfunction

    function automatic int gcyc_at(input int idx);
        return (idx < grant_cyc.size()) ? grant_cyc[idx] : -1;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            in_frame[i] = 1'b0;
            silent[i]   = 1'b0;
            done_cnt[i] = 0;
        end
        exp_q.delete();
        acc_prev   = '0;
        done_exp   = '0;
        grant_prev = '0;
        to_exp     = 1'b0;
        nv_cnt     = 0;
        nv_seen    = 1'b0;
        to_cnt     = 0;
        to_cycle   = -1;
        done_cycle = -1;
        src_req_en = '0;
        src_tvalid = '0;
        src_tlast  = '0;
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn = 1'b0;
        repeat (2) @(negedge aclk);
        clear_model();
        aresetn = 1'b1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_grant"},   74'(src_grant),   74'(0));
        check({tag, "_tready"},  74'(src_tready),  74'(0));
        check({tag, "_done"},    74'(src_done),    74'(0));
        check({tag, "_timeout"}, 74'(timeout_err), 74'(0));
        check({tag, "_m_axis"},
              74'({m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata}), 74'(0));
    endtask

    task automatic add_frame(input int src, input int n, input int n_exp);
        logic [72:0] b;
        for (int k = 0; k < n; k++) begin
            b[63:0]  = {8'(src), 8'(k), 16'(frame_id), 32'($urandom)};
            b[71:64] = (k == n - 1) ? 8'h0F : 8'hFF;
            b[72]    = (k == n - 1);
            src_q[src].push_back(b);
            if (k < n_exp) exp_q.push_back(b);
        end
        frame_id++;
    endtask

    // ---------------- driver: one clock cycle of source and MAC behaviour ----------------
    task automatic step(input logic rdy);
        logic [72:0] b;
        @(negedge aclk);
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (acc_prev[i] && src_q[i].size() > 0) begin
                b = src_q[i].pop_front();
                if (b[72]) in_frame[i] = 1'b0;
            end
            if (src_grant[i]) in_frame[i] = 1'b1;
            src_req_en[i] = (src_q[i].size() > 0) && !in_frame[i];
            if (src_grant[i] && src_q[i].size() > 0 && !silent[i]) begin
                b = src_q[i][0];
                src_tvalid[i]          = 1'b1;
                src_tlast[i]           = b[72];
                src_tkeep[8*i +: 8]    = b[71:64];
                src_tdata[64*i +: 64]  = b[63:0];
            end else begin
                src_tvalid[i]          = 1'b0;
                src_tlast[i]           = 1'($urandom_range(0, 1));
                src_tkeep[8*i +: 8]    = 8'($urandom);
                src_tdata[64*i +: 64]  = {$urandom, $urandom};
            end
        end
        m_axis_tready = rdy;
    endtask

    // ---------------- compare: rules every cycle, scoreboard on accepted beats ----------------
    task automatic compare_cycle();
        int          g;
        logic [73:0] exp_m;
        logic [72:0] e;
        g = -1;
        for (int i = 0; i < N; i++) if (src_grant[i]) g = i;

        check("grant_onehot", 74'($countones(src_grant) <= 1), 74'(1));
        if (g >= 0)
            exp_m = {src_tvalid[g], src_tlast[g], src_tkeep[8*g +: 8], src_tdata[64*g +: 64]};
        else
            exp_m = '0;
        check("m_axis_mux", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata}, exp_m);
        check("src_tready", 74'(src_tready), 74'(src_grant & {N{m_axis_tready}}));
        check("src_done", 74'(src_done), 74'(done_exp));
        check("timeout_err", 74'(timeout_err), 74'(to_exp));
        if (to_exp) check("grant_drop_on_timeout", 74'(src_grant), 74'(0));
        if (|src_done) check("done_in_gap", 74'(dbg_state), 74'(GAP));

        if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                check("mac_beat_unexpected", 74'(m_axis_tdata), 74'(0));
                if (m_axis_tdata == 64'd0) begin
                    errors++;
                    $display("FAIL mac_beat_unexpected cycle=%0d got=beat expected=none", cyc);
                end
            end else begin
                e = exp_q.pop_front();
                check("mac_beat", 74'({m_axis_tlast, m_axis_tkeep, m_axis_tdata}), 74'(e));
            end
        end

        st_at[cyc % 256] = dbg_state;
        if (g >= 0 && src_grant != grant_prev) begin
            grant_order.push_back(g);
            grant_cyc.push_back(cyc);
        end
        grant_prev = src_grant;
        for (int i = 0; i < N; i++) begin
            if (src_done[i]) begin
                done_cnt[i]++;
                done_cycle = cyc;
            end
        end
        if (timeout_err) begin
            to_cnt++;
            to_cycle = cyc;
        end

        // expectations for the next cycle
        acc_prev = src_tvalid & src_tready;
        done_exp = src_tvalid & src_tready & src_tlast;
        to_exp   = 1'b0;
        if (g >= 0) begin
            if (src_tvalid[g]) nv_seen = 1'b1;
            if (!nv_seen) nv_cnt++;
            if (!nv_seen && nv_cnt == TMO) to_exp = 1'b1;
        end else begin
            nv_cnt  = 0;
            nv_seen = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(negedge aclk);
            #2;
            if (aresetn && chk_en) compare_cycle();
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int base;
        int req_c;
        logic pat [4];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

        clear_model();
        src_tvalid    = '1;
        src_tdata     = {N{64'hDEAD_BEEF_0123_4567}};
        src_tkeep     = '1;
        m_axis_tready = 1'b1;
        #2;
        check_quiet("reset");
        do_reset();
        chk_en = 1'b1;

        // single ICMP frame, 5 beats
        add_frame(SRC_ICMP, 5, 5);
        base = grant_order.size();
        step(1'b1);
        req_c = cyc;
        repeat (11) step(1'b1);
        check("t1_order", 74'(order_at(base)), 74'(SRC_ICMP));
        check("t1_grant_latency", 74'(gcyc_at(base)), 74'(req_c + 1));
        check("t1_done_cycle", 74'(done_cycle), 74'(req_c + 6));
        check("t1_done_count", 74'(done_cnt[SRC_ICMP]), 74'(1));
        check("t1_gap_state", 74'(st_at[(req_c + 6) % 256]), 74'(GAP));
        check("t1_idle_after_gap", 74'(st_at[(req_c + 7) % 256]), 74'(IDLE));
        check("t1_drained", 74'(exp_q.size()), 74'(0));

        // all three at once, then ARP alone, then all three again from rr_ptr=1
        do_reset();
        add_frame(SRC_ARP, 3, 3);
        add_frame(SRC_ICMP, 3, 3);
        add_frame(SRC_UDP, 3, 3);
        base = grant_order.size();
        repeat (20) step(1'b1);
        check("t2_order0", 74'(order_at(base)),     74'(0));
        check("t2_order1", 74'(order_at(base + 1)), 74'(1));
        check("t2_order2", 74'(order_at(base + 2)), 74'(2));
        check("t2_spacing01", 74'(gcyc_at(base + 1) - gcyc_at(base)), 74'(5));
        check("t2_spacing12", 74'(gcyc_at(base + 2) - gcyc_at(base + 1)), 74'(5));
        check("t2_done_each", 74'({done_cnt[0], done_cnt[1], done_cnt[2]}), 74'({32'd1, 32'd1, 32'd1}));
        add_frame(SRC_ARP, 2, 2);
        repeat (8) step(1'b1);
        add_frame(SRC_ICMP, 3, 3);
        add_frame(SRC_UDP, 3, 3);
        add_frame(SRC_ARP, 3, 3);
        repeat (20) step(1'b1);
        check("t2_arp_alone", 74'(order_at(base + 3)), 74'(0));
        check("t2_rot_order0", 74'(order_at(base + 4)), 74'(1));
        check("t2_rot_order1", 74'(order_at(base + 5)), 74'(2));
        check("t2_rot_order2", 74'(order_at(base + 6)), 74'(0));
        check("t2_drained", 74'(exp_q.size()), 74'(0));

        // UDP frame with MAC backpressure 1,0,0,1
        do_reset();
        add_frame(SRC_UDP, 4, 4);
        base = grant_order.size();
        for (int k = 0; k < 30; k++) step(pat[k % 4]);
        check("t3_order", 74'(order_at(base)), 74'(SRC_UDP));
        check("t3_done_count", 74'(done_cnt[SRC_UDP]), 74'(1));
        check("t3_drained", 74'(exp_q.size()), 74'(0));

        // ARP granted but silent: timeout, then pending ICMP is served
        do_reset();
        silent[SRC_ARP] = 1'b1;
        add_frame(SRC_ARP, 1, 0);
        add_frame(SRC_ICMP, 2, 2);
        base = grant_order.size();
        step(1'b1);
        req_c = cyc;
        repeat (29) step(1'b1);
        check("t4_first_arp", 74'(order_at(base)), 74'(SRC_ARP));
        check("t4_arp_grant", 74'(gcyc_at(base)), 74'(req_c + 1));
        check("t4_timeout_cycle", 74'(to_cycle), 74'(req_c + 17));
        check("t4_timeout_count", 74'(to_cnt), 74'(1));
        check("t4_then_icmp", 74'(order_at(base + 1)), 74'(SRC_ICMP));
        check("t4_icmp_grant", 74'(gcyc_at(base + 1)), 74'(req_c + 19));
        check("t4_no_arp_done", 74'(done_cnt[SRC_ARP]), 74'(0));
        check("t4_icmp_done", 74'(done_cnt[SRC_ICMP]), 74'(1));
        check("t4_drained", 74'(exp_q.size()), 74'(0));

        // reset asserted while beat 2 of a 6-beat ARP frame is on the bus
        do_reset();
        add_frame(SRC_ARP, 6, 2);
        repeat (3) step(1'b1);
        #3;
        aresetn = 1'b0;
        #1;
        check_quiet("t5_midreset");
        check("t5_beats_before_reset", 74'(exp_q.size()), 74'(0));
        repeat (2) @(negedge aclk);
        clear_model();
        aresetn = 1'b1;
        add_frame(SRC_ARP, 2, 2);
        base = grant_order.size();
        step(1'b1);
        req_c = cyc;
        repeat (7) step(1'b1);
        check("t5_regrant", 74'(order_at(base)), 74'(SRC_ARP));
        check("t5_regrant_latency", 74'(gcyc_at(base)), 74'(req_c + 1));
        check("t5_done_count", 74'(done_cnt[SRC_ARP]), 74'(1));
        check("t5_drained", 74'(exp_q.size()), 74'(0));

        // single-beat UDP frame: GRANT -> GAP -> IDLE
        do_reset();
        add_frame(SRC_UDP, 1, 1);
        base = grant_order.size();
        step(1'b1);
        req_c = cyc;
        repeat (7) step(1'b1);
        check("t6_grant_state", 74'(st_at[(req_c + 1) % 256]), 74'(GRANT));
        check("t6_gap_state",   74'(st_at[(req_c + 2) % 256]), 74'(GAP));
        check("t6_idle_state",  74'(st_at[(req_c + 3) % 256]), 74'(IDLE));
        check("t6_done_cycle",  74'(done_cycle), 74'(req_c + 2));
        check("t6_done_count",  74'(done_cnt[SRC_UDP]), 74'(1));
        check("t6_drained",     74'(exp_q.size()), 74'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
